// File: rtl/ppu_vram_bus_responder.sv
// rtl/ppu_vram_bus_responder.sv - memory-side responder for the PPU multiplexed VRAM bus
// Latches the address, decodes CHR/nametable space with mirroring, serves reads and commits writes.
module ppu_vram_bus_responder #(
    parameter int    CHR_WRITABLE  = 1,
    parameter string CHR_INIT_FILE = "",
    parameter string NT_INIT_FILE  = ""
) (
    input  logic        clock_IN,
    input  logic        reset_IN,
    inout  wire  [13:0] addressData_IN_OUT,
    input  logic        addressLatch_EN,
    input  logic        read_EN,
    input  logic        write_EN,
    input  logic [1:0]  mirrorMode_IN,
    output logic        busConflict_OUT,
    output logic [7:0]  romWriteDrop_OUT,
    output logic [15:0] readCount_OUT,
    output logic [15:0] writeCount_OUT
);

    logic [7:0]  r_chr_mem [0:8191];
    logic [7:0]  r_nt_mem  [0:2047];

    logic [13:0] r_addr;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_wr_data;
    logic        r_rd_n_q;
    logic        r_wr_n_q;
    logic        r_rd_abort;
    logic        r_wr_abort;
    logic        r_conflict;
    logic [7:0]  r_rom_drop;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    logic [7:0]  w_bus_lo;
    logic [5:0]  w_bus_hi;
    logic        w_is_chr;
    logic        w_is_nt;
    logic        w_mapped;
    logic [10:0] w_nt_idx;
    logic [12:0] w_chr_idx;
    logic        w_viol;
    logic        w_drive;
    logic        w_rd_rise;
    logic        w_wr_rise;
    logic        w_commit_chr;
    logic        w_commit_nt;
    logic        w_drop;

    assign w_bus_lo  = addressData_IN_OUT[7:0];
    assign w_bus_hi  = addressData_IN_OUT[13:8];

    assign w_is_chr  = (r_addr < 14'h2000);
    assign w_is_nt   = (r_addr >= 14'h2000) && (r_addr < 14'h3F00);
    assign w_mapped  = w_is_chr || w_is_nt;
    assign w_chr_idx = r_addr[12:0];

    // A12 never reaches the nametable index, so 0x3000-0x3EFF aliases 0x2000-0x2EFF.
    always_comb begin
        w_nt_idx = {1'b0, r_addr[9:0]};
        case (mirrorMode_IN)
            2'd0:    w_nt_idx = {r_addr[11], r_addr[9:0]};
            2'd1:    w_nt_idx = {r_addr[10], r_addr[9:0]};
            2'd2:    w_nt_idx = {1'b0, r_addr[9:0]};
            default: w_nt_idx = {1'b1, r_addr[9:0]};
        endcase
    end

    assign w_viol = (!read_EN && !write_EN) ||
                    (addressLatch_EN && (!read_EN || !write_EN));

    assign w_drive = !reset_IN && !read_EN && !addressLatch_EN && w_mapped && !w_viol;
    assign addressData_IN_OUT[7:0] = w_drive ? r_rd_data : 8'bzzzz_zzzz;

    assign w_rd_rise    = read_EN && !r_rd_n_q && !r_rd_abort;
    assign w_wr_rise    = write_EN && !r_wr_n_q && !r_wr_abort && !reset_IN;
    assign w_commit_chr = w_wr_rise && w_is_chr && (CHR_WRITABLE != 0);
    assign w_commit_nt  = w_wr_rise && w_is_nt;
    assign w_drop       = w_wr_rise && w_is_chr && (CHR_WRITABLE == 0);

    always_ff @(posedge clock_IN) begin
        if (w_commit_chr) begin
            r_chr_mem[w_chr_idx] <= r_wr_data;
        end
        if (w_commit_nt) begin
            r_nt_mem[w_nt_idx] <= r_wr_data;
        end
        r_rd_data <= w_is_chr ? r_chr_mem[w_chr_idx] : r_nt_mem[w_nt_idx];
        if (!write_EN) begin
            r_wr_data <= w_bus_lo;
        end
    end

    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            r_addr     <= '0;
            r_rd_n_q   <= 1'b1;
            r_wr_n_q   <= 1'b1;
            // A strobe already low through reset must not complete after it.
            r_rd_abort <= !read_EN;
            r_wr_abort <= !write_EN;
            r_conflict <= 1'b0;
            r_rom_drop <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (addressLatch_EN) begin
                r_addr <= {w_bus_hi, w_bus_lo};
            end
            r_rd_n_q   <= read_EN;
            r_wr_n_q   <= write_EN;
            r_rd_abort <= !read_EN && r_rd_abort;
            r_wr_abort <= !write_EN && (r_wr_abort || w_viol);
            if (w_viol) begin
                r_conflict <= 1'b1;
            end
            if (w_rd_rise && w_mapped) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_commit_chr || w_commit_nt) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_drop && (r_rom_drop != 8'hFF)) begin
                r_rom_drop <= r_rom_drop + 8'd1;
            end
        end
    end

    assign busConflict_OUT  = r_conflict;
    assign romWriteDrop_OUT = r_rom_drop;
    assign readCount_OUT    = r_rd_count;
    assign writeCount_OUT   = r_wr_count;

endmodule

// File: tb/tb_ppu_vram_bus_responder.sv
// tb/tb_ppu_vram_bus_responder.sv - randomized bench with a transaction-level memory model
module tb_ppu_vram_bus_responder;

    localparam int CHR_W = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic [1:0]  mode;
    logic [5:0]  tb_hi;
    logic [7:0]  tb_lo;
    logic        tb_oe;
    wire  [13:0] bus;
    wire         conflict;
    wire  [7:0]  drop;
    wire  [15:0] rc;
    wire  [15:0] wc;

    always #5 clk = ~clk;

    assign bus[13:8] = tb_hi;
    assign bus[7:0]  = tb_oe ? tb_lo : 8'bzzzz_zzzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (bus[g]);
    end

    ppu_vram_bus_responder #(
        .CHR_WRITABLE (CHR_W),
        .CHR_INIT_FILE(""),
        .NT_INIT_FILE ("")
    ) dut (
        .clock_IN          (clk),
        .reset_IN          (rst),
        .addressData_IN_OUT(bus),
        .addressLatch_EN   (ale),
        .read_EN           (rd_n),
        .write_EN          (wr_n),
        .mirrorMode_IN     (mode),
        .busConflict_OUT   (conflict),
        .romWriteDrop_OUT  (drop),
        .readCount_OUT     (rc),
        .writeCount_OUT    (wc)
    );

    logic [7:0] m_chr [8192];
    logic [7:0] m_nt  [2048];
    int         m_rc;
    int         m_wc;
    int         m_drop;
    int         m_conf;
    logic [7:0] exp_lo;
    bit         cmp_en;
    int         checks;
    int         errors;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bus_lo", int'(bus[7:0]), int'(exp_lo));
            chk("conflict", int'(conflict), m_conf);
            chk("rom_drop", int'(drop), m_drop);
            chk("read_count", int'(rc), m_rc & 'hFFFF);
            chk("write_count", int'(wc), m_wc & 'hFFFF);
        end
    end

    function automatic int nt_idx(int a, int md);
        int page;
        case (md)
            0:       page = (a >> 11) & 1;
            1:       page = (a >> 10) & 1;
            2:       page = 0;
            default: page = 1;
        endcase
        return page * 1024 + (a % 1024);
    endfunction

    function automatic bit mapped(int a);
        return a < 'h3F00;
    endfunction

    function automatic logic [7:0] mread(int a, int md);
        if (a < 'h2000) return m_chr[a];
        return m_nt[nt_idx(a, md)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit a, bit r, bit w, bit oe, logic [7:0] lo, logic [7:0] ex);
        ale    = a;
        rd_n   = r;
        wr_n   = w;
        tb_oe  = oe;
        tb_lo  = lo;
        exp_lo = ex;
    endtask

    task automatic model_reset();
        m_rc   = 0;
        m_wc   = 0;
        m_drop = 0;
        m_conf = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1, 1, 0, 8'h00, 8'hFF);
        tick();
        model_reset();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_ale(int a, int md);
        mode  = 2'(md);
        tb_hi = 6'((a >> 8) & 'h3F);
        drive(1, 1, 1, 1, 8'(a & 'hFF), 8'(a & 'hFF));
        tick();
    endtask

    task automatic do_read(int a, int md, int len, output logic [7:0] seen);
        logic [7:0] ex;
        seen = 8'h00;
        do_ale(a, md);
        repeat (2) begin
            drive(0, 1, 1, 0, 8'h00, 8'hFF);
            tick();
        end
        for (int i = 0; i < len; i++) begin
            ex = mapped(a) ? mread(a, md) : 8'hFF;
            drive(0, 0, 1, 0, 8'h00, ex);
            if (i == 0) begin
                #3 seen = bus[7:0];
            end
            tick();
        end
        drive(0, 1, 1, 0, 8'h00, 8'hFF);
        tick();
        if (mapped(a)) m_rc++;
    endtask

    // kind: 0 normal, 1 read overlaps low cycle 1, 2 reset during low cycle 1
    task automatic do_write(int a, int md, int len, logic [7:0] d, logic [7:0] d_last, int kind);
        bit         aborted;
        logic [7:0] dv;
        aborted = 1'b0;
        do_ale(a, md);
        for (int i = 0; i < len; i++) begin
            dv = (i == len - 1) ? d_last : d;
            if (kind == 1 && i == 1) begin
                drive(0, 0, 0, 0, 8'h00, 8'hFF);
                tick();
                m_conf  = 1;
                aborted = 1'b1;
            end else begin
                drive(0, 1, 0, 1, dv, dv);
                if (kind == 2 && i == 1) rst = 1'b1;
                tick();
                rst = 1'b0;
                if (kind == 2 && i == 1) begin
                    model_reset();
                    aborted = 1'b1;
                end
                if (kind == 1 && i == 2 && mapped(a)) m_rc++;
            end
        end
        drive(0, 1, 1, 0, 8'h00, 8'hFF);
        tick();
        if (!aborted) begin
            if (a < 'h2000) begin
                if (CHR_W != 0) begin
                    m_chr[a] = d_last;
                    m_wc++;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (a < 'h3F00) begin
                m_nt[nt_idx(a, md)] = d_last;
                m_wc++;
            end
        end
    endtask

    initial begin
        logic [7:0] seen;
        int         a;
        int         r;
        int         md;
        int         ln;
        logic [7:0] d;
        logic [7:0] d2;

        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst    = 1'b0;
        mode   = 2'd0;
        tb_hi  = 6'd0;
        drive(0, 1, 1, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 8192; i++) begin
            m_chr[i] = 8'((i * 7 + 3) & 'hFF);
        end
        m_chr[16] = 8'h12;
        for (int i = 0; i < 2048; i++) begin
            m_nt[i] = 8'((i * 5 + 1) & 'hFF);
        end
        for (int i = 0; i < 8192; i++) dut.r_chr_mem[i] = m_chr[i];
        for (int i = 0; i < 2048; i++) dut.r_nt_mem[i] = m_nt[i];
        model_reset();

        do_reset();
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_read_count", int'(rc), 0);
        chk("rst_write_count", int'(wc), 0);
        chk("rst_rom_drop", int'(drop), 0);

        do_write('h2005, 0, 2, 8'hA5, 8'hA5, 0);
        do_read('h2005, 0, 2, seen);
        chk("nt_rw_data", int'(seen), 'hA5);
        chk("nt_rw_wcount", int'(wc), 1);
        chk("nt_rw_rcount", int'(rc), 1);

        do_write('h2400, 1, 1, 8'h3C, 8'h3C, 0);
        do_read('h2C00, 1, 1, seen);
        chk("vert_alias", int'(seen), 'h3C);
        do_read('h2000, 1, 1, seen);
        chk("vert_other_page", int'(seen), 'h01);

        do_write('h2000, 0, 1, 8'h77, 8'h77, 0);
        do_read('h2400, 0, 1, seen);
        chk("horiz_alias", int'(seen), 'h77);
        do_read('h3000, 0, 1, seen);
        chk("a12_alias", int'(seen), 'h77);

        do_write('h0010, 0, 2, 8'hFF, 8'hFF, 0);
        do_read('h0010, 0, 1, seen);
        chk("rom_keeps_data", int'(seen), 'h12);
        chk("rom_drop_one", int'(drop), 1);
        chk("rom_no_wcount", int'(wc), 3);

        do_write('h2123, 0, 5, 8'h11, 8'h22, 0);
        do_read('h2123, 0, 1, seen);
        chk("long_wr_last_data", int'(seen), 'h22);
        chk("long_wr_one_count", int'(wc), 4);

        do_read('h3F00, 0, 2, seen);
        chk("palette_released", int'(seen), 'hFF);
        chk("palette_no_rcount", int'(rc), 7);

        do_write('h2100, 0, 3, 8'h5A, 8'h5A, 1);
        chk("conflict_sticky", int'(conflict), 1);
        do_read('h2100, 0, 1, seen);
        chk("conflict_no_commit", int'(seen), 'h01);
        chk("conflict_no_wcount", int'(wc), 4);

        do_reset();
        chk("reset_clears_conflict", int'(conflict), 0);

        do_write('h2001, 0, 3, 8'h99, 8'h99, 2);
        chk("reset_mid_wr_count", int'(wc), 0);
        do_read('h2001, 0, 1, seen);
        chk("reset_mid_wr_data", int'(seen), 'h06);

        for (int i = 0; i < 300; i++) begin
            do_write(i % 64, 0, 1, 8'(i), 8'(i), 0);
        end
        chk("rom_drop_saturates", int'(drop), 255);
        chk("rom_sat_no_wcount", int'(wc), 0);

        for (int t = 0; t < 400; t++) begin
            md = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 99));
            a  = int'($urandom_range(0, 9));
            if (a < 2) a = int'($urandom_range(0, 8191));
            else if (a < 9) a = 'h2000 | (int'($urandom_range(0, 7)) << 10) | int'($urandom_range(0, 3));
            else a = 'h3F00 + int'($urandom_range(0, 255));
            d  = 8'($urandom);
            d2 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : d;
            if (r < 45) begin
                do_read(a, md, int'($urandom_range(1, 3)), seen);
            end else if (r < 88) begin
                ln = int'($urandom_range(1, 4));
                do_write(a, md, ln, d, (ln > 1) ? d2 : d, 0);
            end else if (r < 95) begin
                do_write(a, md, int'($urandom_range(3, 4)), d, d2, 1);
            end else begin
                do_write(a, md, int'($urandom_range(3, 4)), d, d2, 2);
            end
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
